// File: rtl/controle_elevador.sv
// controle_elevador: SCAN scheduler for the elevator car.
// The controller reads the latched floor requests and moves the car one floor at a time.
// It keeps its current direction while requests remain ahead of the car.
// It stops at every requested floor and holds the door open there.
// While the door is open, cl clears the request of the floor being served.
module controle_elevador #(
    parameter int N_ANDARES = 16,
    parameter int T_MOVE    = 50,
    parameter int T_PORTA   = 200
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_ANDARES-1:0]         estadobotao,
    output logic [N_ANDARES-1:0]         cl,
    output logic [$clog2(N_ANDARES)-1:0] andar,
    output logic                         subindo,
    output logic                         movendo,
    output logic                         porta_aberta
);

    localparam int AW   = $clog2(N_ANDARES);
    localparam int TMAX = (T_PORTA > T_MOVE) ? T_PORTA : T_MOVE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [N_ANDARES-1:0] UM_N        = {{(N_ANDARES-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]        CARGA_MOVE  = TW'(T_MOVE - 1);
    localparam logic [TW-1:0]        CARGA_PORTA = TW'(T_PORTA - 1);

    typedef enum logic [1:0] {
        PARADO = 2'd0,
        MOVER  = 2'd1,
        PORTA  = 2'd2
    } estado_t;

    estado_t                estado_r, estado_nx_s;
    logic [TW-1:0]          timer_r, timer_nx_s;
    logic [AW-1:0]          andar_r, andar_nx_s;
    logic                   subindo_r, subindo_nx_s;
    logic                   movendo_r, movendo_nx_s;
    logic                   porta_r, porta_nx_s;
    logic [N_ANDARES-1:0]   cl_r, cl_nx_s;

    logic [N_ANDARES-1:0]   onehot_s;
    logic [N_ANDARES-1:0]   mascara_abaixo_s;
    logic [N_ANDARES-1:0]   mascara_acima_s;
    logic                   aqui_s;
    logic                   acima_s;
    logic                   abaixo_s;

    assign cl           = cl_r;
    assign andar        = andar_r;
    assign subindo      = subindo_r;
    assign movendo      = movendo_r;
    assign porta_aberta = porta_r;

    // Request flags relative to the current floor: the floor itself, floors above, floors below
    always_comb begin
        onehot_s         = UM_N << andar_r;
        mascara_abaixo_s = onehot_s - UM_N;
        mascara_acima_s  = ~(mascara_abaixo_s | onehot_s);
        aqui_s           = |(estadobotao & onehot_s);
        acima_s          = |(estadobotao & mascara_acima_s);
        abaixo_s         = |(estadobotao & mascara_abaixo_s);
    end

    // Next-state and next-output logic; every register holds its value unless a branch changes it
    always_comb begin
        estado_nx_s  = estado_r;
        timer_nx_s   = timer_r;
        andar_nx_s   = andar_r;
        subindo_nx_s = subindo_r;
        movendo_nx_s = movendo_r;
        porta_nx_s   = porta_r;
        cl_nx_s      = cl_r;
        case (estado_r)
            PARADO: begin
                if (aqui_s) begin
                    estado_nx_s = PORTA;
                    timer_nx_s  = CARGA_PORTA;
                    porta_nx_s  = 1'b1;
                    cl_nx_s     = onehot_s;
                end else if (subindo_r && acima_s) begin
                    estado_nx_s  = MOVER;
                    timer_nx_s   = CARGA_MOVE;
                    movendo_nx_s = 1'b1;
                end else if (!subindo_r && abaixo_s) begin
                    estado_nx_s  = MOVER;
                    timer_nx_s   = CARGA_MOVE;
                    movendo_nx_s = 1'b1;
                end else if (acima_s) begin
                    // Nothing ahead in the current direction: reverse to go up
                    estado_nx_s  = MOVER;
                    timer_nx_s   = CARGA_MOVE;
                    movendo_nx_s = 1'b1;
                    subindo_nx_s = 1'b1;
                end else if (abaixo_s) begin
                    // Nothing ahead in the current direction: reverse to go down
                    estado_nx_s  = MOVER;
                    timer_nx_s   = CARGA_MOVE;
                    movendo_nx_s = 1'b1;
                    subindo_nx_s = 1'b0;
                end else begin
                    estado_nx_s = PARADO;
                end
            end
            MOVER: begin
                if (timer_r == {TW{1'b0}}) begin
                    estado_nx_s  = PARADO;
                    movendo_nx_s = 1'b0;
                    if (subindo_r) begin
                        andar_nx_s = andar_r + AW'(1);
                    end else begin
                        andar_nx_s = andar_r - AW'(1);
                    end
                end else begin
                    timer_nx_s = timer_r - TW'(1);
                end
            end
            PORTA: begin
                if (timer_r == {TW{1'b0}}) begin
                    estado_nx_s = PARADO;
                    porta_nx_s  = 1'b0;
                    cl_nx_s     = {N_ANDARES{1'b0}};
                end else begin
                    timer_nx_s = timer_r - TW'(1);
                end
            end
            default: begin
                // Unreachable encoding: return to a safe, idle decision state
                estado_nx_s  = PARADO;
                timer_nx_s   = {TW{1'b0}};
                movendo_nx_s = 1'b0;
                porta_nx_s   = 1'b0;
                cl_nx_s      = {N_ANDARES{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset to floor 0, heading up, idle
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r  <= PARADO;
            timer_r   <= {TW{1'b0}};
            andar_r   <= {AW{1'b0}};
            subindo_r <= 1'b1;
            movendo_r <= 1'b0;
            porta_r   <= 1'b0;
            cl_r      <= {N_ANDARES{1'b0}};
        end else begin
            estado_r  <= estado_nx_s;
            timer_r   <= timer_nx_s;
            andar_r   <= andar_nx_s;
            subindo_r <= subindo_nx_s;
            movendo_r <= movendo_nx_s;
            porta_r   <= porta_nx_s;
            cl_r      <= cl_nx_s;
        end
    end

endmodule

// File: tb/tb_controle_elevador.sv
// Testbench for controle_elevador with T_MOVE=4, T_PORTA=8 and 16 floors.
// The bench models the button latch: a pending bit is dropped once cl covers it.
module tb_controle_elevador;

    logic        clock;
    logic        reset;
    logic [15:0] estadobotao;
    logic [15:0] cl;
    logic [3:0]  andar;
    logic        subindo;
    logic        movendo;
    logic        porta_aberta;

    int checks = 0;
    int errors = 0;
    logic        prev_porta = 1'b0;
    logic [15:0] door_log[$];

    controle_elevador #(
        .N_ANDARES (16),
        .T_MOVE    (4),
        .T_PORTA   (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .estadobotao  (estadobotao),
        .cl           (cl),
        .andar        (andar),
        .subindo      (subindo),
        .movendo      (movendo),
        .porta_aberta (porta_aberta)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        int          n;
        logic [3:0]  e_andar;
        logic        e_sub;
        logic        e_mov;
        logic        e_por;
        logic [15:0] e_cl;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] a, input logic s,
                            input logic m, input logic p, input logic [15:0] c);
        chk(name, {9'd0, andar, subindo, movendo, porta_aberta, cl},
                  {9'd0, a, s, m, p, c});
    endtask

    // One clock: sample #1 after the edge, log door openings, model latch clearing
    task automatic cyc();
        @(posedge clock);
        #1;
        if (porta_aberta && !prev_porta) door_log.push_back(cl);
        prev_porta  = porta_aberta;
        estadobotao = estadobotao & ~cl;
    endtask

    task automatic run_until_idle(input string name);
        int k;
        k = 0;
        cyc();
        while (!(estadobotao == 16'h0000 && !movendo && !porta_aberta) && k < 500) begin
            cyc();
            k++;
        end
        chk({name, "_timeout"}, k < 500, 1'b1);
    endtask

    task automatic check_log(input string name, input int n, input logic [15:0] e0, input logic [15:0] e1);
        chk({name, "_count"}, door_log.size(), n);
        chk({name, "_stop0"}, (door_log.size() > 0) ? door_log[0] : 16'h0000, e0);
        chk({name, "_stop1"}, (door_log.size() > 1) ? door_log[1] : 16'h0000, e1);
        door_log.delete();
    endtask

    initial begin
        int k;
        // Single-floor service at floor 0, then 0 -> 3 trip with door at 3
        tbl[0]  = '{1'b0, 16'h0001, 1, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0001};
        tbl[1]  = '{1'b0, 16'h0000, 7, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0001};
        tbl[2]  = '{1'b0, 16'h0000, 1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 16'h0000, 3, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0008, 1, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 16'h0000, 3, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 16'h0000, 1, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[7]  = '{1'b0, 16'h0000, 1, 4'd1, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 16'h0000, 4, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 16'h0000, 5, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 16'h0000, 1, 4'd3, 1'b1, 1'b0, 1'b1, 16'h0008};
        tbl[11] = '{1'b0, 16'h0000, 7, 4'd3, 1'b1, 1'b0, 1'b1, 16'h0008};
        tbl[12] = '{1'b0, 16'h0000, 1, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0000};

        reset       = 1'b1;
        estadobotao = 16'h0000;

        // Reset held two cycles, then idle and stable for 20 cycles
        cyc();
        cyc();
        chk_outs("reset_state", 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_outs("idle_stable", 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        end

        // Table-driven timing of the door and the first trip
        for (int i = 0; i < 13; i++) begin
            reset       = tbl[i].rst;
            estadobotao = estadobotao | tbl[i].req;
            for (int j = 0; j < tbl[i].n; j++) cyc();
            chk_outs($sformatf("vec%0d", i), tbl[i].e_andar, tbl[i].e_sub,
                     tbl[i].e_mov, tbl[i].e_por, tbl[i].e_cl);
        end
        door_log.delete();

        // Move to floor 5 heading up, then requests on both sides (9 and 2)
        estadobotao = estadobotao | 16'h0020;
        run_until_idle("to5");
        check_log("to5_log", 1, 16'h0020, 16'h0000);
        chk_outs("at5", 4'd5, 1'b1, 1'b0, 1'b0, 16'h0000);
        estadobotao = estadobotao | 16'h0204;
        run_until_idle("scan");
        check_log("scan_log", 2, 16'h0200, 16'h0004);
        chk_outs("at2_down", 4'd2, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Go to floor 0, then trip to 6 with an intermediate request at 4
        estadobotao = estadobotao | 16'h0001;
        run_until_idle("to0");
        check_log("to0_log", 1, 16'h0001, 16'h0000);
        estadobotao = estadobotao | 16'h0040;
        k = 0;
        cyc();
        while (andar != 4'd2 && k < 200) begin
            cyc();
            k++;
        end
        chk("reach2_timeout", k < 200, 1'b1);
        estadobotao = estadobotao | 16'h0010;
        run_until_idle("to6");
        check_log("to6_log", 2, 16'h0010, 16'h0040);
        chk_outs("at6", 4'd6, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Reset while moving up from floor 7
        estadobotao = estadobotao | 16'h0100;
        k = 0;
        cyc();
        while (!(andar == 4'd7 && movendo) && k < 200) begin
            cyc();
            k++;
        end
        chk("reach7_timeout", k < 200, 1'b1);
        reset       = 1'b1;
        estadobotao = 16'h0000;
        cyc();
        chk_outs("reset_in_mover", 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        cyc();
        chk_outs("after_reset_mover", 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Reset while the door is open at floor 3, approached going down
        estadobotao = estadobotao | 16'h0020;
        run_until_idle("to5b");
        estadobotao = estadobotao | 16'h0008;
        k = 0;
        cyc();
        while (!(porta_aberta && andar == 4'd3) && k < 200) begin
            cyc();
            k++;
        end
        chk("reach3_timeout", k < 200, 1'b1);
        cyc();
        cyc();
        chk_outs("door3_down", 4'd3, 1'b0, 1'b0, 1'b1, 16'h0008);
        reset = 1'b1;
        cyc();
        chk_outs("reset_in_porta", 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        cyc();
        chk_outs("after_reset_porta", 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
